caesar_key_recover: RTL and testbench

- Known-plaintext key recovery for the Caesar cipher datapath. The inverse direction of the encrypt/decrypt path: takes (plaintext, cyphertext) pairs and recovers the key that maps one to the other.
- Collects a fixed number of pairs over a valid/ready handshake and checks that every pair implies the same key.
- Reports the key, or a mismatch or range error, in the 0..25 domain used by the key switches and 7-seg key display.

---
 rtl/caesar_key_recover.sv | 118 +++++++++++
 tb/tb_caesar_key_recover.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/caesar_key_recover.sv
// Recovers a Caesar key from PAIR_COUNT (plaintext, cyphertext) pairs; the result registers on the terminating accept edge, and done pulses the cycle after.
// in_ready is high only in COLLECT; a stalled in_valid simply holds state.
module caesar_key_recover #(
  parameter int WIDTH      = 6,
  parameter int MOD        = 26,
  parameter int PAIR_COUNT = 4
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] plaintext,
  input  logic [WIDTH-1:0] cyphertext,
  output logic             busy,
  output logic             done,
  output logic [4:0]       key,
  output logic             key_valid,
  output logic             mismatch,
  output logic             range_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [WIDTH:0] MOD_W     = (WIDTH+1)'(MOD);
  localparam logic [5:0]     PAIR_LAST = 6'(PAIR_COUNT - 1);

  state_t         state;
  logic [5:0]     pair_cnt;
  logic [WIDTH:0] p_ext;
  logic [WIDTH:0] c_ext;
  logic [WIDTH:0] diff;
  logic           out_of_range;
  logic           accept;
  logic           key_differs;

  // Modular subtraction by a single conditional add of MOD, avoiding a divider.
  always_comb begin
    p_ext        = {1'b0, plaintext};
    c_ext        = {1'b0, cyphertext};
    diff         = (c_ext >= p_ext) ? (c_ext - p_ext) : (c_ext + MOD_W - p_ext);
    out_of_range = (p_ext >= MOD_W) || (c_ext >= MOD_W);
    accept       = (state == COLLECT) && in_valid && in_ready;
    key_differs  = (diff != {{(WIDTH-4){1'b0}}, key});
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pair_cnt  <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      mismatch  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            pair_cnt  <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            mismatch  <= 1'b0;
            range_err <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (out_of_range) begin
              range_err <= 1'b1;
              key_valid <= 1'b0;
              state     <= DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              pair_cnt <= pair_cnt + 6'd1;
              if (pair_cnt == '0) begin
                key <= diff[4:0];
              end
              // The first pair defines the candidate, so it can never mismatch.
              if ((pair_cnt != '0) && key_differs) begin
                mismatch  <= 1'b1;
                key_valid <= 1'b0;
                state     <= DONE;
                in_ready  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else if (pair_cnt == PAIR_LAST) begin
                key_valid <= 1'b1;
                state     <= DONE;
                in_ready  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_caesar_key_recover.sv
// Directed bench for caesar_key_recover: the driver queues expected results and a monitor checks every done pulse against them.
module tb_caesar_key_recover;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] plaintext = '0;
  logic [5:0] cyphertext = '0;
  logic       busy;
  logic       done;
  logic [4:0] key;
  logic       key_valid;
  logic       mismatch;
  logic       range_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0] key;
    logic       kv;
    logic       mm;
    logic       re;
    logic [7:0] acc;
  } exp_t;

  exp_t exp_q[$];

  caesar_key_recover #(.WIDTH(6), .MOD(26), .PAIR_COUNT(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .cyphertext(cyphertext),
    .busy      (busy),
    .done      (done),
    .key       (key),
    .key_valid (key_valid),
    .mismatch  (mismatch),
    .range_err (range_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_key"}, 32'(key), 0);
    check({tag, "_key_valid"}, 32'(key_valid), 0);
    check({tag, "_mismatch"}, 32'(mismatch), 0);
    check({tag, "_range_err"}, 32'(range_err), 0);
  endtask

  // Monitor: counts accepts, compares each done pulse with the queue head.
  initial begin : monitor
    int  acc;
    bit  prev_done;
    exp_t e;
    acc = 0;
    prev_done = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!rst) begin
        acc = 0;
        prev_done = 0;
      end else begin
        if (prev_done) check("done_one_cycle", 32'(done), 0);
        prev_done = done;
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("res_key", 32'(key), 32'(e.key));
            check("res_key_valid", 32'(key_valid), 32'(e.kv));
            check("res_mismatch", 32'(mismatch), 32'(e.mm));
            check("res_range_err", 32'(range_err), 32'(e.re));
            check("res_accepts", 32'(acc), 32'(e.acc));
            check("res_exclusive", 32'(key_valid) + 32'(mismatch) + 32'(range_err), 1);
          end
          acc = 0;
        end
        if (in_valid && in_ready) acc++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] p, input logic [5:0] c, input int gap, output bit ok);
    plaintext  = p;
    cyphertext = c;
    in_valid   = 1'b1;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic send_chk(input logic [5:0] p, input logic [5:0] c, input int gap);
    bit ok;
    send(p, c, gap, ok);
    check("pair_accepted", 32'(ok), 1);
  endtask

  function automatic exp_t mk(input logic [4:0] k, input logic kv, input logic mm,
                              input logic re, input logic [7:0] acc);
    exp_t e;
    e.key = k; e.kv = kv; e.mm = mm; e.re = re; e.acc = acc;
    return e;
  endfunction

  initial begin : driver
    bit ok;
    repeat (3) tick();
    check_all_zero("reset");
    @(negedge CLOCK_50);
    rst = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    // Consistent run: (3,7) x4, back to back.
    exp_q.push_back(mk(5'd4, 1, 0, 0, 8'd4));
    do_start();
    check("collect_busy", 32'(busy), 1);
    check("collect_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) send_chk(6'd3, 6'd7, 0);
    repeat (3) tick();
    check("idle_busy", 32'(busy), 0);

    // Wrap-around with one-cycle stalls; start held through the done cycle.
    exp_q.push_back(mk(5'd4, 1, 0, 0, 8'd4));
    do_start();
    send_chk(6'd24, 6'd2, 1);
    send_chk(6'd25, 6'd3, 1);
    send_chk(6'd0, 6'd4, 1);
    send_chk(6'd10, 6'd14, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("start_in_done_ignored", 32'(busy), 0);
    check("hold_key", 32'(key), 4);
    check("hold_key_valid", 32'(key_valid), 1);

    // Start edge clears the previous flags; then (0,0) x4.
    exp_q.push_back(mk(5'd0, 1, 0, 0, 8'd4));
    do_start();
    check("start_clears_key", 32'(key), 0);
    check("start_clears_key_valid", 32'(key_valid), 0);
    for (int i = 0; i < 4; i++) send_chk(6'd0, 6'd0, 0);
    repeat (3) tick();

    // Mismatch on the second pair; start while busy is ignored.
    exp_q.push_back(mk(5'd4, 0, 1, 0, 8'd2));
    do_start();
    send_chk(6'd3, 6'd7, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_collect_busy", 32'(busy), 1);
    send_chk(6'd5, 6'd10, 0);
    send(6'd1, 6'd5, 0, ok);
    check("no_accept_after_mismatch", 32'(ok), 0);
    tick();

    // Range error after a good pair, then as the first pair.
    exp_q.push_back(mk(5'd4, 0, 0, 1, 8'd2));
    do_start();
    send_chk(6'd3, 6'd7, 0);
    send_chk(6'd26, 6'd4, 0);
    repeat (3) tick();
    exp_q.push_back(mk(5'd0, 0, 0, 1, 8'd1));
    do_start();
    send_chk(6'd26, 6'd30, 0);
    repeat (3) tick();

    // Asynchronous reset mid-run: no done, outputs drop immediately.
    do_start();
    send_chk(6'd3, 6'd7, 0);
    send_chk(6'd3, 6'd7, 0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) tick();
    @(negedge CLOCK_50);
    rst = 1'b1;
    tick();
    exp_q.push_back(mk(5'd0, 1, 0, 0, 8'd4));
    do_start();
    for (int i = 0; i < 4; i++) send_chk(6'd1, 6'd1, 0);
    repeat (4) tick();

    check("all_results_seen", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
